// File: rtl/mxv_tx_scheduler.sv
// Streams a result vector to a UART TX byte by byte: high byte, low byte per
// element, then a terminator. One handshake (issue/ack/drain) per byte.
module mxv_tx_scheduler #(
  parameter int         MAX_N     = 8,
  parameter logic [7:0] TERM_BYTE = 8'h0A,
  parameter int         ACK_TO    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  n,
  output logic [2:0]  rd_idx,
  input  logic [15:0] rd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_ACK, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] PH_HI   = 2'd0;
  localparam logic [1:0] PH_LO   = 2'd1;
  localparam logic [1:0] PH_TERM = 2'd2;

  state_t     state_q, state_d;
  logic [7:0] n_q, n_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;

  logic n_bad, last_elem;
  assign n_bad     = (n_q == 8'd0) || (n_q > 8'(MAX_N));
  assign last_elem = ({5'd0, cnt_q} == (n_q - 8'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      phase_q   <= PH_HI;
      tx_data_q <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      tx_data_q <= tx_data_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    tx_data_d = tx_data_q;
    to_d      = to_q;
    err_d     = err_q;
    tx_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          cnt_d   = '0;
          phase_d = PH_HI;
          err_d   = 1'b0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (n_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          case (phase_q)
            PH_HI:   tx_data_d = rd_data[15:8];
            PH_LO:   tx_data_d = rd_data[7:0];
            default: tx_data_d = TERM_BYTE;
          endcase
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          to_d     = '0;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        // The UART must acknowledge by raising busy; otherwise give up.
        if (tx_busy) begin
          state_d = S_DRAIN;
        end else if (to_q == 8'(ACK_TO - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if (phase_q == PH_TERM) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LATCH;
            if (phase_q == PH_HI) begin
              phase_d = PH_LO;
            end else if (last_elem) begin
              phase_d = PH_TERM;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              phase_d = PH_HI;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = done && err_q;
  assign rd_idx  = cnt_q;
  assign tx_data = tx_data_q;

endmodule

// File: doc/mxv_tx_scheduler.md
MXV_TX_SCHEDULER -- requirements
Module: mxv_tx_scheduler

Interface
REQ-001 Parameter: MAX_N, 8, maximum vector length; legal range 1..8.
REQ-002 Parameter: TERM_BYTE, 8'h0A, terminator byte sent after the last element.
REQ-003 Parameter: ACK_TO, 255, number of cycles to wait in ACK for tx_busy; legal range 1..255.
REQ-004 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  single-cycle request to transmit a result vector.
REQ-007 Port: n  in  8  number of result elements to send.
REQ-008 Port: rd_idx  out  3  element index presented to the result store.
REQ-009 Port: rd_data  in  16  element at rd_idx, combinationally valid in the same cycle.
REQ-010 Port: tx_start  out  1  single-cycle byte-send strobe to the UART TX.
REQ-011 Port: tx_data  out  8  byte to send.
REQ-012 Port: tx_busy  in  1  UART TX busy; high while a byte is in flight.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: done  out  1  single-cycle pulse at the end of every accepted request.
REQ-015 Port: err  out  1  single-cycle pulse, coincident with done, on an illegal n or an ack timeout.

Function
REQ-016 The FSM SHALL have states IDLE, LATCH, ISSUE, ACK, DRAIN and DONE.
REQ-017 In IDLE, when start=1, n SHALL be latched into n_q, the element counter and byte phase SHALL be cleared, and the FSM SHALL go to LATCH.
REQ-018 start SHALL be ignored in every state except IDLE, and changes on n after latching SHALL have no effect.
REQ-019 If the latched n is 0 or greater than MAX_N, the FSM SHALL go from LATCH to DONE with err set, and SHALL not assert tx_start.
REQ-020 The byte order SHALL be: for elements 0..n_q-1, rd_data[15:8] then rd_data[7:0]; then TERM_BYTE. Total bytes = 2*n_q+1.
REQ-021 rd_idx SHALL equal the element counter.
REQ-022 In LATCH, the current byte (high byte, low byte, or TERM_BYTE) SHALL be registered into tx_data, and the FSM SHALL go to ISSUE.
REQ-023 In ISSUE, tx_start SHALL be 1 for exactly one cycle once tx_busy=0, and the FSM SHALL then go to ACK.
REQ-024 While tx_busy=1 in ISSUE, the FSM SHALL wait with tx_start=0.
REQ-025 tx_data SHALL be held stable from ISSUE until DRAIN exits.
REQ-026 In ACK, the FSM SHALL go to DRAIN when tx_busy=1.
REQ-027 If ACK_TO cycles elapse in ACK without tx_busy=1, the FSM SHALL abort to DONE with err set.
REQ-028 In DRAIN, when tx_busy=0, the FSM SHALL go to DONE if TERM_BYTE was just sent; otherwise it SHALL advance the phase/counter and go to LATCH.
REQ-029 Element counter advance: 0..n_q-1, no wrap; the counter SHALL advance only after the low byte.
REQ-030 In DONE, done SHALL be 1 (and err if flagged), and the FSM SHALL return to IDLE the next cycle.
REQ-031 A start pulse arriving in the DONE cycle SHALL be ignored.
REQ-032 Latency: with tx_busy=0, tx_start SHALL be high in the 2nd cycle after the cycle in which start is sampled.
REQ-033 Each subsequent byte SHALL take 3 cycles plus the UART busy duration.

Reset
REQ-034 On reset=0, the FSM SHALL go to IDLE, and tx_start, tx_data, rd_idx, busy, done, err, the counters and n_q SHALL all be 0.
REQ-035 Reset asserted mid-transfer SHALL abort immediately, with no done or err pulse.
REQ-036 After reset deassertion, the block SHALL accept start on the first rising edge.

Verification
REQ-037 n=1, rd_data[0]=16'h1234, UART model busy 10 cycles per byte -> tx_data sequence 12,34,0A; 3 tx_start pulses; one done; err=0.
REQ-038 n=8, rd_data[i]=16'hA0B0+i -> 17 bytes A0,B0,A0,B1,...,A0,B7,0A, in order; rd_idx 0..7.
REQ-039 n=0, then n=9 -> per request, done=err=1 together; tx_start never asserted; busy high for 2 cycles.
REQ-040 n=2 with tx_busy held 0 after the first tx_start -> err+done exactly ACK_TO cycles after entering ACK; no further tx_start.
REQ-041 start pulsed again during an n=3 transfer and n changed to 1 mid-transfer -> 7 bytes sent; one done.
REQ-042 Reset asserted during the DRAIN of byte 3 -> all outputs 0 next edge; a fresh start with n=1 yields 3 correct bytes.
